// File: rtl/priority_grant_sequencer_if.sv
// Handshake bundle between the priority detector / actuator side and the
// grant sequencer.
//   in_x, in_y : one-hot priority code from the detector (outX, outY)
//   ack        : actuator acknowledge of the current grant
//   grant_x/y  : held grant per channel
//   busy       : sequencer is not idle
//   timeout    : one-cycle pulse, grant expired without ack
//   conflict   : sticky flag, both code lines were seen high together
//   cnt_x/y    : saturating count of acknowledged grants per channel
// master drives the code and ack; slave (the sequencer) drives the rest.
interface priority_grant_sequencer_if #(
  parameter int CNT_W = 4
) ();
  logic             in_x;
  logic             in_y;
  logic             ack;
  logic             grant_x;
  logic             grant_y;
  logic             busy;
  logic             timeout;
  logic             conflict;
  logic [CNT_W-1:0] cnt_x;
  logic [CNT_W-1:0] cnt_y;

  modport master (
    output in_x, in_y, ack,
    input  grant_x, grant_y, busy, timeout, conflict, cnt_x, cnt_y
  );

  modport slave (
    input  in_x, in_y, ack,
    output grant_x, grant_y, busy, timeout, conflict, cnt_x, cnt_y
  );
endinterface

// File: rtl/priority_grant_sequencer.sv
// Priority grant sequencer: qualifies a one-hot code from the priority
// detector for STABLE_CYCLES consecutive edges, then holds a grant on the
// matching channel until ack or until HOLD_CYCLES cycles elapse. Acked
// grants are counted per channel (saturating). An event is granted once;
// the code must return to 00 before a new one is accepted.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears every register
//   bus   : slave side of priority_grant_sequencer_if (see that file)
// All outputs are registered.
module priority_grant_sequencer #(
  parameter int STABLE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 4,
  parameter int CNT_W         = 4
) (
  input logic                       clk,
  input logic                       reset,
  priority_grant_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0]       STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]       HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [1:0]       cap_q, cap_d;
  logic [7:0]       qcnt_q, qcnt_d;
  logic [7:0]       hcnt_q, hcnt_d;
  logic             grant_x_q, grant_x_d;
  logic             grant_y_q, grant_y_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0] cnt_y_q, cnt_y_d;

  logic [1:0] code;
  logic       is_single;
  logic       is_illegal;

  assign code       = {bus.in_y, bus.in_x};
  assign is_single  = (code == 2'b01) || (code == 2'b10);
  assign is_illegal = (code == 2'b11);

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    qcnt_d     = qcnt_q;
    hcnt_d     = hcnt_q;
    cnt_x_d    = cnt_x_q;
    cnt_y_d    = cnt_y_q;
    timeout_d  = 1'b0;
    conflict_d = conflict_q | is_illegal;

    case (state_q)
      IDLE: begin
        if (is_single) begin
          cap_d   = code;
          qcnt_d  = 8'd1;
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (code == cap_q) begin
          if (qcnt_q == STABLE_LAST) begin
            hcnt_d  = 8'd0;
            state_d = GRANT;
          end else begin
            qcnt_d = qcnt_q + 8'd1;
          end
        end else if (is_single) begin
          // A different single code restarts qualification on that channel.
          cap_d  = code;
          qcnt_d = 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // The code is deliberately ignored here; only ack or expiry leave.
        if (bus.ack) begin
          if (cap_q[0] && (cnt_x_q != CNT_MAX)) cnt_x_d = cnt_x_q + 1'b1;
          if (cap_q[1] && (cnt_y_q != CNT_MAX)) cnt_y_d = cnt_y_q + 1'b1;
          state_d = RELEASE;
        end else if (hcnt_q == HOLD_LAST) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (code == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the decoded next state so they line
    // up with the state register.
    grant_x_d = (state_d == GRANT) && cap_d[0];
    grant_y_d = (state_d == GRANT) && cap_d[1];
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_q      <= 2'b00;
      qcnt_q     <= 8'd0;
      hcnt_q     <= 8'd0;
      grant_x_q  <= 1'b0;
      grant_y_q  <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      conflict_q <= 1'b0;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      qcnt_q     <= qcnt_d;
      hcnt_q     <= hcnt_d;
      grant_x_q  <= grant_x_d;
      grant_y_q  <= grant_y_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      conflict_q <= conflict_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
    end
  end

  assign bus.grant_x  = grant_x_q;
  assign bus.grant_y  = grant_y_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;
  assign bus.conflict = conflict_q;
  assign bus.cnt_x    = cnt_x_q;
  assign bus.cnt_y    = cnt_y_q;

endmodule

// File: tb/tb_priority_grant_sequencer.sv
module tb_priority_grant_sequencer;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;

  priority_grant_sequencer_if #(.CNT_W(CNT_W)) bus ();

  priority_grant_sequencer #(
    .STABLE_CYCLES(3),
    .HOLD_CYCLES  (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed outputs: {grant_x, grant_y, busy, timeout, conflict, cnt_x, cnt_y}
  typedef struct {
    logic        x;
    logic        y;
    logic        ack;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt;
  int   total_cnt;

  function automatic logic [12:0] outs();
    return {bus.grant_x, bus.grant_y, bus.busy, bus.timeout, bus.conflict,
            bus.cnt_x, bus.cnt_y};
  endfunction

  task automatic add(input logic x, input logic y, input logic ack,
                     input logic gx, input logic gy, input logic bsy,
                     input logic to, input logic cf,
                     input logic [3:0] cx, input logic [3:0] cy);
    vec_t v;
    v.x   = x;
    v.y   = y;
    v.ack = ack;
    v.exp = {gx, gy, bsy, to, cf, cx, cy};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] got,
                       input logic [12:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got gx/gy/busy/to/cf=%b cnt_x=%0d cnt_y=%0d, required %b cnt_x=%0d cnt_y=%0d",
                  name, got[12:8], got[7:4], got[3:0], exp[12:8], exp[7:4], exp[3:0]);
  endtask

  task automatic drive_cycle(input logic x, input logic y, input logic ack);
    @(negedge clk);
    bus.in_x = x;
    bus.in_y = y;
    bus.ack  = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] cx_model;
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    bus.in_x  = 1'b0;
    bus.in_y  = 1'b0;
    bus.ack   = 1'b0;

    //   x  y  ack  gx gy bsy to cf cx  cy
    // 01 held 6 edges, ack on 2nd grant cycle, then 00 (ack in IDLE ignored)
    add(1,0,0, 0,0,1,0,0, 0,0);
    add(1,0,0, 0,0,1,0,0, 0,0);
    add(1,0,0, 1,0,1,0,0, 0,0);
    add(1,0,0, 1,0,1,0,0, 0,0);
    add(1,0,1, 0,0,1,0,0, 1,0);
    add(1,0,0, 0,0,1,0,0, 1,0);
    add(0,0,0, 0,0,0,0,0, 1,0);
    add(0,0,1, 0,0,0,0,0, 1,0);
    // 10 for 2 edges then 00: no grant
    add(0,1,0, 0,0,1,0,0, 1,0);
    add(0,1,0, 0,0,1,0,0, 1,0);
    add(0,0,0, 0,0,0,0,0, 1,0);
    // 01 x2 then 10 x3: requalify on 10, ack on first grant cycle
    add(1,0,0, 0,0,1,0,0, 1,0);
    add(1,0,0, 0,0,1,0,0, 1,0);
    add(0,1,0, 0,0,1,0,0, 1,0);
    add(0,1,0, 0,0,1,0,0, 1,0);
    add(0,1,0, 0,1,1,0,0, 1,0);
    add(0,1,1, 0,0,1,0,0, 1,1);
    add(0,0,0, 0,0,0,0,0, 1,1);
    // 10 qualified, no ack: grant 4 cycles, one timeout pulse; code ignored in GRANT
    add(0,1,0, 0,0,1,0,0, 1,1);
    add(0,1,0, 0,0,1,0,0, 1,1);
    add(0,1,0, 0,1,1,0,0, 1,1);
    add(0,1,0, 0,1,1,0,0, 1,1);
    add(0,0,0, 0,1,1,0,0, 1,1);
    add(1,0,0, 0,1,1,0,0, 1,1);
    add(0,1,0, 0,0,1,1,0, 1,1);
    add(0,0,1, 0,0,0,0,0, 1,1);
    // 11 in IDLE: conflict sticky, no grant; normal traffic afterwards
    add(1,1,0, 0,0,0,0,1, 1,1);
    add(0,0,0, 0,0,0,0,1, 1,1);
    add(1,0,0, 0,0,1,0,1, 1,1);
    add(1,0,0, 0,0,1,0,1, 1,1);
    add(1,0,0, 1,0,1,0,1, 1,1);
    add(1,0,1, 0,0,1,0,1, 2,1);
    add(0,0,0, 0,0,0,0,1, 2,1);
    // 11 during QUALIFY aborts to IDLE
    add(0,1,0, 0,0,1,0,1, 2,1);
    add(1,1,0, 0,0,0,0,1, 2,1);
    add(0,0,0, 0,0,0,0,1, 2,1);

    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", outs(), 13'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].x, tbl[i].y, tbl[i].ack);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // 17 back-to-back acked X events: cnt_x saturates at 15
    cx_model = 4'd2;
    for (int ev = 0; ev < 17; ev++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b0);
      if (cx_model != 4'd15) cx_model = cx_model + 4'd1;
      check($sformatf("sat_ev%0d", ev), outs(), {5'b00001, cx_model, 4'd1});
    end

    // Reset asserted mid-GRANT clears everything without a clock edge
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    check("pre_reset_grant", outs(), {5'b01101, 4'd15, 4'd1});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), 13'd0);
    @(negedge clk);
    reset    = 1'b0;
    bus.in_x = 1'b0;
    bus.in_y = 1'b0;
    bus.ack  = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0);
    check("post_reset_idle", outs(), 13'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
